// File: rtl/led_arbiter.sv
// Round-robin arbiter that hands an LED bank to one of N_REQ requesters with a minimum dwell time.
// Define LED_ARB_PRIO0_EN to give requester 0 absolute priority in every arbitration.
module led_arbiter #(
  parameter int LED_W        = 8,
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       led,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SWITCH
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_next;
  logic [15:0]      r_count;
  logic [15:0]      w_count_next;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_next;
  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_led_next;
  logic             r_busy;
  logic             w_busy_next;

  logic [LED_W-1:0] w_slice [N_REQ];
  logic [N_REQ-1:0] w_owner_oh;
  logic [N_REQ-1:0] w_next_oh;
  logic             w_others_req;
  logic             w_win_valid;
  logic [IDX_W-1:0] w_win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_slice[gi]    = pattern[gi*LED_W +: LED_W];
      assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
      assign w_next_oh[gi]  = (w_owner_next == IDX_W'(gi));
    end
  endgenerate

  assign w_others_req = |(req & ~w_owner_oh);

  // Scan from the farthest candidate to the nearest so the first requester after r_owner wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(r_owner) + k) % N_REQ]) begin
        w_win_valid = 1'b1;
        w_win_idx   = IDX_W'((int'(r_owner) + k) % N_REQ);
      end
    end
`ifdef LED_ARB_PRIO0_EN
    if (req[0]) begin
      w_win_valid = 1'b1;
      w_win_idx   = '0;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= IDX_W'(N_REQ - 1);
      r_count <= '0;
      r_grant <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_count <= w_count_next;
      r_grant <= w_grant_next;
      r_led   <= w_led_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state logic; a req[0] at count==0 already counts as "another requester".
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_next = S_HOLD;
          w_owner_next = w_win_idx;
          w_count_next = DWELL_LOAD;
        end
      end
      S_HOLD: begin
        if (!req[r_owner]) begin
          w_state_next = S_SWITCH;
          w_count_next = '0;
        end else if ((r_count == '0) && w_others_req) begin
          w_state_next = S_SWITCH;
        end else if (r_count == '0) begin
          w_count_next = DWELL_LOAD;
        end else begin
          w_count_next = r_count - 16'd1;
        end
      end
      S_SWITCH: begin
        if (w_win_valid) begin
          w_state_next = S_HOLD;
          w_owner_next = w_win_idx;
          w_count_next = DWELL_LOAD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  // Outputs follow the upcoming state so they are registered alongside it.
  always_comb begin
    w_grant_next = '0;
    w_led_next   = '0;
    w_busy_next  = 1'b0;
    if (w_state_next == S_HOLD) begin
      w_grant_next = w_next_oh;
      w_led_next   = w_slice[w_owner_next];
      w_busy_next  = 1'b1;
    end
  end

  assign grant = r_grant;
  assign led   = r_led;
  assign busy  = r_busy;

endmodule
